// File: rtl/reg_file_pkg.sv
// Shared register-file types and default sizes for the MIPS datapath blocks
// (register file, decoder, operand muxes).
package reg_file_pkg;

   localparam int DATA_WIDTH_DEF = 16;
   localparam int ADDR_WIDTH_DEF = 2;

   typedef logic [ADDR_WIDTH_DEF-1:0] reg_addr_t;
   typedef logic [DATA_WIDTH_DEF-1:0] reg_data_t;

endpackage

// File: rtl/reg_file_sb_scoreboard.sv
// Pending-write scoreboard: one bit per architectural register, raised at issue
// and dropped at writeback, with busy flags for both read ports and a live count.
module reg_scoreboard
   import reg_file_pkg::*;
#(
   parameter int ADDR_WIDTH = ADDR_WIDTH_DEF,
   parameter bit BYPASS     = 1'b1
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic [ADDR_WIDTH-1:0] rr1_i,
   input  logic [ADDR_WIDTH-1:0] rr2_i,
   input  logic [ADDR_WIDTH-1:0] wr_i,
   input  logic                  regwrite_i,
   input  logic                  issue_valid_i,
   input  logic [ADDR_WIDTH-1:0] issue_rd_i,
   output logic                  busy1_o,
   output logic                  busy2_o,
   output logic [ADDR_WIDTH:0]   pending_cnt_o
);

   localparam int REGS = 2 ** ADDR_WIDTH;
   localparam int CW   = ADDR_WIDTH + 1;

   logic [REGS-1:0] pend_q, pend_d;
   logic [CW-1:0]   cnt_q, cnt_d;

   // Clear first, then set, so a new producer supersedes the one completing.
   always_comb begin
      pend_d = pend_q;
      if (regwrite_i && (wr_i != '0))
         pend_d[wr_i] = 1'b0;
      if (issue_valid_i && (issue_rd_i != '0))
         pend_d[issue_rd_i] = 1'b1;
      pend_d[0] = 1'b0;
   end

   always_comb begin
      cnt_d = '0;
      for (int i = 1; i < REGS; i++)
         cnt_d = cnt_d + CW'(pend_d[i]);
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         pend_q <= '0;
         cnt_q  <= '0;
      end else begin
         pend_q <= pend_d;
         cnt_q  <= cnt_d;
      end
   end

   // A register completing this cycle is forwarded, so it is not busy with bypass on.
   assign busy1_o = pend_q[rr1_i] & ~(BYPASS && regwrite_i && (wr_i == rr1_i));
   assign busy2_o = pend_q[rr2_i] & ~(BYPASS && regwrite_i && (wr_i == rr2_i));
   assign pending_cnt_o = cnt_q;

endmodule

// File: rtl/reg_file_sb.sv
// Parametrised MIPS register file: two combinational read ports, one write port,
// register 0 hardwired to zero, optional write-to-read bypass and RAW scoreboard.
module reg_file_sb
   import reg_file_pkg::*;
#(
   parameter int DATA_WIDTH = DATA_WIDTH_DEF,
   parameter int ADDR_WIDTH = ADDR_WIDTH_DEF,
   parameter bit BYPASS     = 1'b1
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic [ADDR_WIDTH-1:0] rr1,
   input  logic [ADDR_WIDTH-1:0] rr2,
   output logic [DATA_WIDTH-1:0] rd1,
   output logic [DATA_WIDTH-1:0] rd2,
   input  logic [ADDR_WIDTH-1:0] wr,
   input  logic [DATA_WIDTH-1:0] wd,
   input  logic                  regwrite,
   input  logic                  issue_valid,
   input  logic [ADDR_WIDTH-1:0] issue_rd,
   output logic                  busy1,
   output logic                  busy2,
   output logic [ADDR_WIDTH:0]   pending_cnt
);

   localparam int REGS = 2 ** ADDR_WIDTH;

   logic [DATA_WIDTH-1:0] regs_q [REGS];

   always_ff @(posedge clock) begin
      if (reset) begin
         for (int i = 0; i < REGS; i++)
            regs_q[i] <= '0;
      end else if (regwrite && (wr != '0)) begin
         regs_q[wr] <= wd;
      end
   end

   always_comb begin
      rd1 = regs_q[rr1];
      if (rr1 == '0)
         rd1 = '0;
      else if (BYPASS && regwrite && (wr == rr1))
         rd1 = wd;
   end

   always_comb begin
      rd2 = regs_q[rr2];
      if (rr2 == '0)
         rd2 = '0;
      else if (BYPASS && regwrite && (wr == rr2))
         rd2 = wd;
   end

   reg_scoreboard #(
      .ADDR_WIDTH (ADDR_WIDTH),
      .BYPASS     (BYPASS)
   ) u_sb (
      .clock         (clock),
      .reset         (reset),
      .rr1_i         (rr1),
      .rr2_i         (rr2),
      .wr_i          (wr),
      .regwrite_i    (regwrite),
      .issue_valid_i (issue_valid),
      .issue_rd_i    (issue_rd),
      .busy1_o       (busy1),
      .busy2_o       (busy2),
      .pending_cnt_o (pending_cnt)
   );

endmodule
